// File: rtl/name_pkg.sv
// Shared name table and streamer types. The CAM and the streamer both read the
// table from here so the two lookup directions always agree.
package name_pkg;

  localparam int ADDR_W   = 3;
  localparam int MAX_LEN  = 8;
  localparam int LEN_W    = 4;
  localparam int DATA_W   = MAX_LEN * 8;
  localparam int ENTRY_W  = LEN_W + DATA_W;

  // Each entry is {len, data}; character 0 sits in data[7:0].
  localparam logic [ENTRY_W-1:0] ENTRY_0 = {4'd3, 64'h0000_0000_004F_454C};  // LEO
  localparam logic [ENTRY_W-1:0] ENTRY_1 = {4'd5, 64'h0000_004E_4F52_4141};  // AARON
  localparam logic [ENTRY_W-1:0] ENTRY_2 = {4'd5, 64'h0000_0059_4C4C_4F48};  // HOLLY
  localparam logic [ENTRY_W-1:0] ENTRY_3 = {4'd5, 64'h0000_0044_4956_4144};  // DAVID
  localparam logic [ENTRY_W-1:0] ENTRY_4 = {4'd6, 64'h0000_4552_4941_4C43};  // CLAIRE
  localparam logic [ENTRY_W-1:0] ENTRY_5 = {4'd5, 64'h0000_004B_4E41_5246};  // FRANK
  localparam logic [ENTRY_W-1:0] ENTRY_6 = {4'd5, 64'h0000_0045_434E_414C};  // LANCE
  localparam logic [ENTRY_W-1:0] ENTRY_7 = {4'd4, 64'h0000_0000_4E41_5952};  // RYAN

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/name_rom.sv
// Combinational name table: address in, {len, data} out.
module name_rom
  import name_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  len,
  output logic [DATA_W-1:0] data
);

  logic [ENTRY_W-1:0] entry_s;

  // Table decode.
  always_comb begin
    entry_s = {ENTRY_W{1'b0}};
    case (addr)
      3'd0:    entry_s = ENTRY_0;
      3'd1:    entry_s = ENTRY_1;
      3'd2:    entry_s = ENTRY_2;
      3'd3:    entry_s = ENTRY_3;
      3'd4:    entry_s = ENTRY_4;
      3'd5:    entry_s = ENTRY_5;
      3'd6:    entry_s = ENTRY_6;
      3'd7:    entry_s = ENTRY_7;
      default: entry_s = {ENTRY_W{1'b0}};
    endcase
  end

  assign len  = entry_s[ENTRY_W-1:DATA_W];
  assign data = entry_s[DATA_W-1:0];

endmodule

// File: rtl/name_streamer.sv
// Streams the name stored at a table address out one ASCII byte per
// valid/ready handshake, flagging the final character with out_last.
module name_streamer
  import name_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              out_valid,
  output logic [7:0]        out_byte,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  state_t             state_r, state_nxt_s;
  logic [DATA_W-1:0]  shreg_r, shreg_nxt_s;
  logic [LEN_W-1:0]   remaining_r, remaining_nxt_s;
  logic               out_valid_r, out_valid_nxt_s;
  logic [7:0]         out_byte_r, out_byte_nxt_s;
  logic               out_last_r, out_last_nxt_s;
  logic [LEN_W-1:0]   rom_len_s;
  logic [DATA_W-1:0]  rom_data_s;

  name_rom u_rom (
    .addr (req_addr),
    .len  (rom_len_s),
    .data (rom_data_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_nxt_s     = state_r;
    shreg_nxt_s     = shreg_r;
    remaining_nxt_s = remaining_r;
    out_valid_nxt_s = out_valid_r;
    out_byte_nxt_s  = out_byte_r;
    out_last_nxt_s  = out_last_r;
    case (state_r)
      IDLE: begin
        // A zero-length entry is swallowed so nothing is ever emitted for it.
        if (req_valid && (rom_len_s != {LEN_W{1'b0}})) begin
          state_nxt_s     = SEND;
          shreg_nxt_s     = rom_data_s;
          remaining_nxt_s = rom_len_s;
          out_valid_nxt_s = 1'b1;
          out_byte_nxt_s  = rom_data_s[7:0];
          out_last_nxt_s  = (rom_len_s == 4'd1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (out_valid_r && out_ready) begin
          if (out_last_r) begin
            state_nxt_s     = IDLE;
            shreg_nxt_s     = {DATA_W{1'b0}};
            remaining_nxt_s = {LEN_W{1'b0}};
            out_valid_nxt_s = 1'b0;
            out_byte_nxt_s  = 8'h00;
            out_last_nxt_s  = 1'b0;
          end else begin
            shreg_nxt_s     = {8'h00, shreg_r[DATA_W-1:8]};
            remaining_nxt_s = remaining_r - 4'd1;
            out_byte_nxt_s  = shreg_r[15:8];
            out_last_nxt_s  = (remaining_r == 4'd2);
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        shreg_nxt_s     = {DATA_W{1'b0}};
        remaining_nxt_s = {LEN_W{1'b0}};
        out_valid_nxt_s = 1'b0;
        out_byte_nxt_s  = 8'h00;
        out_last_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      shreg_r     <= {DATA_W{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
      out_valid_r <= 1'b0;
      out_byte_r  <= 8'h00;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shreg_r     <= shreg_nxt_s;
      remaining_r <= remaining_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_byte_r  <= out_byte_nxt_s;
      out_last_r  <= out_last_nxt_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_byte  = out_byte_r;
  assign out_last  = out_last_r;
  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_name_streamer.sv
// Scoreboard bench for name_streamer: requests push expected bytes, a monitor
// pops and compares on every output handshake.
module tb_name_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic       req_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int bytes_seen = 0;
  int lasts_seen = 0;
  logic [8:0] exp_q[$];

  string names [8] = '{"LEO", "AARON", "HOLLY", "DAVID", "CLAIRE", "FRANK", "LANCE", "RYAN"};

  name_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  // Monitor: compares each handshaken byte and checks stability during stalls.
  initial begin
    logic       stall;
    logic [8:0] stall_v;
    logic [8:0] e;
    stall = 1'b0;
    stall_v = 9'd0;
    forever begin
      @(negedge clk);
      if (stall)
        check("stall_hold", {54'd0, out_valid, out_last, out_byte}, {54'd0, 1'b1, stall_v});
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", out_byte);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", {56'd0, out_byte}, {56'd0, e[7:0]});
          check("out_last", {63'd0, out_last}, {63'd0, e[8]});
        end
        bytes_seen++;
        if (out_last) lasts_seen++;
      end
      stall = rst_n && out_valid && !out_ready;
      stall_v = {out_last, out_byte};
    end
  end

  task automatic push_name(input int a);
    string nm;
    nm = names[a];
    for (int i = 0; i < nm.len(); i++)
      exp_q.push_back({(i == nm.len() - 1), nm[i]});
  endtask

  // Holds req_valid until accepted; checks the idle gap and first-byte latency.
  task automatic do_req(input int a, input bit expect_wait);
    int  n;
    bit  saw_busy;
    bit  ok;
    @(posedge clk);
    #2;
    req_valid = 1'b1;
    req_addr = a[2:0];
    n = 0;
    saw_busy = 1'b0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      else begin
        saw_busy = 1'b1;
        n++;
      end
    end
    if (!ok) begin
      fail_timeout("req_accept");
      req_valid = 1'b0;
    end else begin
      if (saw_busy) begin
        check("gap_queue_empty", 64'(exp_q.size()), 64'd0);
        check("gap_out_valid", {63'd0, out_valid}, 64'd0);
      end
      if (expect_wait) check("held_while_busy", {63'd0, saw_busy}, 64'd1);
      @(posedge clk);
      push_name(a);
      #2;
      req_valid = 1'b0;
      check("first_byte_latency", {61'd0, out_valid, busy, req_ready}, 64'b110);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) fail_timeout("drain");
  endtask

  initial begin
    int  b0;
    int  l0;
    bit  hit;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_outputs", {52'd0, out_valid, out_byte, out_last, busy, 2'b00}, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // LEO with out_ready held high.
    out_ready = 1'b1;
    do_req(0, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      #1;
      if (lasts_seen == 1) hit = 1'b1;
    end
    if (!hit) fail_timeout("leo_last");
    @(negedge clk);
    check("leo_req_ready_back", {62'd0, req_ready, out_valid}, 64'b10);
    check("leo_byte_count", 64'(bytes_seen), 64'd3);

    // CLAIRE with out_ready toggling.
    b0 = bytes_seen;
    l0 = lasts_seen;
    do_req(4, 1'b0);
    for (int k = 0; k < 40 && (exp_q.size() != 0 || out_valid); k++) begin
      @(posedge clk);
      #2;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    wait_drain();
    check("claire_handshakes", 64'(bytes_seen - b0), 64'd6);
    check("claire_lasts", 64'(lasts_seen - l0), 64'd1);

    // RYAN requested while HOLLY is streaming.
    b0 = bytes_seen;
    do_req(2, 1'b0);
    do_req(7, 1'b1);
    wait_drain();
    check("holly_ryan_bytes", 64'(bytes_seen - b0), 64'd9);

    // Reset in the middle of AARON, then FRANK.
    b0 = bytes_seen;
    do_req(1, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      #1;
      if (bytes_seen == b0 + 2) hit = 1'b1;
    end
    if (!hit) fail_timeout("aaron_two_bytes");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {61'd0, out_valid, out_last, busy}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release", {62'd0, req_ready, out_valid}, 64'b10);
    b0 = bytes_seen;
    do_req(5, 1'b0);
    wait_drain();
    check("frank_bytes", 64'(bytes_seen - b0), 64'd5);

    // Sweep all eight entries back-to-back.
    b0 = bytes_seen;
    l0 = lasts_seen;
    for (int a = 0; a < 8; a++) do_req(a, 1'b0);
    wait_drain();
    check("sweep_bytes", 64'(bytes_seen - b0), 64'd38);
    check("sweep_lasts", 64'(lasts_seen - l0), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
